smc_input_loader: RTL and testbench

//  Serial-to-parallel front end for the six-transistor MOSFET current/transconductance

---
 rtl/smc_input_loader.sv | 97 +++++++++
 tb/tb_smc_input_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/smc_input_loader.sv
// Serial-to-parallel frame loader: collects N_TR (W, V_GS, V_DS) beats into one
// registered frame on a valid/ready output and flags frames containing V_GS==0.
module smc_input_loader #(
  parameter int unsigned N_TR = 6,
  parameter int unsigned DW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode_in,
  input  logic [DW-1:0]        w_in,
  input  logic [DW-1:0]        vgs_in,
  input  logic [DW-1:0]        vds_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           mode,
  output logic [N_TR*DW-1:0]   w_bus,
  output logic [N_TR*DW-1:0]   vgs_bus,
  output logic [N_TR*DW-1:0]   vds_bus,
  output logic                 vgs_zero,
  output logic [2:0]           beat_cnt
);

  localparam int unsigned BW   = N_TR * DW;
  localparam logic [2:0]  LAST = 3'(N_TR - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic [2:0] slot;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and target slot
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    slot      = 3'd0;
    accept    = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      LOAD: begin
        in_ready = 1'b1;
        slot     = beat_cnt;
      end
      FULL:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid & in_ready;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (accept && beat_cnt == LAST) state_nxt = FULL;
      FULL: if (out_ready) state_nxt = accept ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; a beat landing in slot 0 starts a new frame and recaptures mode/flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      beat_cnt  <= 3'd0;
      mode      <= 2'b00;
      w_bus     <= BW'(0);
      vgs_bus   <= BW'(0);
      vds_bus   <= BW'(0);
      vgs_zero  <= 1'b0;
    end else begin
      out_valid <= (state_nxt == FULL);
      if (accept) begin
        for (int unsigned k = 0; k < N_TR; k++) begin
          if (slot == 3'(k)) begin
            w_bus[DW*k +: DW]   <= w_in;
            vgs_bus[DW*k +: DW] <= vgs_in;
            vds_bus[DW*k +: DW] <= vds_in;
          end
        end
        if (slot == 3'd0) begin
          mode     <= mode_in;
          vgs_zero <= (vgs_in == DW'(0));
        end else begin
          vgs_zero <= vgs_zero | (vgs_in == DW'(0));
        end
        beat_cnt <= (state_nxt == FULL) ? 3'd0 : 3'(slot + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_smc_input_loader.sv
// Directed scoreboard bench for smc_input_loader: stimulus pushes expected frames,
// a negedge monitor pops and compares on every output handshake.
module tb_smc_input_loader;

  localparam int unsigned N_TR = 6;
  localparam int unsigned DW   = 3;
  localparam int unsigned BW   = N_TR * DW;

  typedef struct {
    logic [1:0]    m;
    logic [BW-1:0] w;
    logic [BW-1:0] g;
    logic [BW-1:0] d;
    logic          vz;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode_in;
  logic [DW-1:0] w_in, vgs_in, vds_in;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    mode;
  logic [BW-1:0] w_bus, vgs_bus, vds_bus;
  logic          vgs_zero;
  logic [2:0]    beat_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int first_acc, last_acc;
  frame_t exp_q[$];
  int     hs_q[$];
  frame_t mon_e;

  smc_input_loader #(.N_TR(N_TR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .w_in(w_in), .vgs_in(vgs_in), .vds_in(vds_in),
    .out_valid(out_valid), .out_ready(out_ready), .mode(mode),
    .w_bus(w_bus), .vgs_bus(vgs_bus), .vds_bus(vds_bus),
    .vgs_zero(vgs_zero), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per output handshake
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_frame: got w_bus %0h expected no frame", w_bus);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_mode", 32'(mode), 32'(mon_e.m));
        chk("sb_w_bus", 32'(w_bus), 32'(mon_e.w));
        chk("sb_vgs_bus", 32'(vgs_bus), 32'(mon_e.g));
        chk("sb_vds_bus", 32'(vds_bus), 32'(mon_e.d));
        chk("sb_vgs_zero", 32'(vgs_zero), 32'(mon_e.vz));
      end
    end
  end

  function automatic frame_t mk(input logic [1:0] m, input logic [BW-1:0] w,
                                input logic [BW-1:0] g, input logic [BW-1:0] d,
                                input logic vz);
    frame_t f;
    f.m = m; f.w = w; f.g = g; f.d = d; f.vz = vz;
    return f;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a beat until accepted; leaves in_valid high for the caller to change
  task automatic send_beat(input logic [1:0] m, input logic [DW-1:0] w,
                           input logic [DW-1:0] g, input logic [DW-1:0] d);
    logic r;
    int   n;
    in_valid = 1'b1;
    mode_in = m; w_in = w; vgs_in = g; vds_in = d;
    n = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    last_acc = cyc;
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [BW-1:0] w,
                            input logic [BW-1:0] g, input logic [BW-1:0] d,
                            input logic vz, input int gap);
    exp_q.push_back(mk(m, w, g, d, vz));
    for (int k = 0; k < N_TR; k++) begin
      send_beat((k == 0) ? m : ~m, w[DW*k +: DW], g[DW*k +: DW], d[DW*k +: DW]);
      if (k == 0) first_acc = last_acc;
      if (k < N_TR - 1) begin
        chk("no_early_valid", 32'(out_valid), 32'd0);
        chk("beat_cnt_mid", 32'(beat_cnt), 32'(k + 1));
      end else begin
        chk("valid_after_last", 32'(out_valid), 32'd1);
      end
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode_in = 2'b00; w_in = '0; vgs_in = '0; vds_in = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_w_bus", 32'(w_bus), 32'd0);
    chk("rst_vgs_zero", 32'(vgs_zero), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Frame 1 with the downstream stalled
    send_frame(2'b11, 18'o654321, 18'o765432, 18'o543210, 1'b0, 0);
    chk("t1_w_bus", 32'(w_bus), 32'(18'o654321));
    chk("t1_vgs_bus", 32'(vgs_bus), 32'(18'o765432));
    chk("t1_vds_bus", 32'(vds_bus), 32'(18'o543210));
    chk("t1_mode", 32'(mode), 32'd3);
    chk("t1_vgs_zero", 32'(vgs_zero), 32'd0);

    // Stall for 5 cycles with a pending beat, then release
    exp_q.push_back(mk(2'b01, 18'o012345, 18'o111111, 18'o707070, 1'b0));
    in_valid = 1'b1; mode_in = 2'b01; w_in = 3'o5; vgs_in = 3'o1; vds_in = 3'o0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_in_ready_stall", 32'(in_ready), 32'd0);
      chk("t2_w_bus_frozen", 32'(w_bus), 32'(18'o654321));
      chk("t2_out_valid_hold", 32'(out_valid), 32'd1);
      chk("t2_beat_cnt_hold", 32'(beat_cnt), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("t2_beat_cnt_1", 32'(beat_cnt), 32'd1);
    chk("t2_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t2_mode_recapture", 32'(mode), 32'd1);
    send_beat(2'b10, 3'o4, 3'o1, 3'o7);
    send_beat(2'b10, 3'o3, 3'o1, 3'o0);
    send_beat(2'b10, 3'o2, 3'o1, 3'o7);
    send_beat(2'b10, 3'o1, 3'o1, 3'o0);
    send_beat(2'b10, 3'o0, 3'o1, 3'o7);
    chk("t2_valid_after_last", 32'(out_valid), 32'd1);
    idle(3);

    // Toggling in_valid: six beats over 11 cycles
    send_frame(2'b10, 18'o135724, 18'o246135, 18'o017263, 1'b0, 1);
    chk("t3_span", 32'(last_acc - first_acc + 1), 32'd11);
    idle(2);

    // V_GS==0 on beat 3, then a clean frame
    send_frame(2'b01, 18'o777777, 18'o123045, 18'o333333, 1'b1, 0);
    chk("t4_vgs_zero_set", 32'(vgs_zero), 32'd1);
    send_frame(2'b00, 18'o111111, 18'o654321, 18'o222222, 1'b0, 0);
    chk("t4_vgs_zero_clear", 32'(vgs_zero), 32'd0);
    idle(2);

    // Reset after 4 beats discards the partial frame
    for (int k = 0; k < 4; k++) send_beat(2'b11, 3'o7, 3'o7, 3'o7);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_beat_cnt_rst", 32'(beat_cnt), 32'd0);
    chk("t5_out_valid_rst", 32'(out_valid), 32'd0);
    send_frame(2'b10, 18'o246246, 18'o531531, 18'o102030, 1'b0, 0);
    idle(2);

    // Three frames streamed back to back
    hs_q.delete();
    send_frame(2'b00, 18'o121212, 18'o343434, 18'o565656, 1'b0, 0);
    send_frame(2'b01, 18'o212121, 18'o434343, 18'o656565, 1'b0, 0);
    send_frame(2'b10, 18'o717171, 18'o252525, 18'o030303, 1'b0, 0);
    idle(3);
    chk("t6_handshakes", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() == 3) begin
      chk("t6_period_a", 32'(hs_q[1] - hs_q[0]), 32'd6);
      chk("t6_period_b", 32'(hs_q[2] - hs_q[1]), 32'd6);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
